// File: rtl/gain_pkg.sv
// gain_pkg: shared types and helpers for the band gain scheduler.
//   gain_sel_t    : 2-bit gain select encoding used by config and the gain unit
//   sched_state_t : scheduler FSM states
//   sat()         : clamp a wide signed value into a signed range of wd bits
package gain_pkg;

  typedef enum logic [1:0] {
    KEEP        = 2'b00,
    REMOVE      = 2'b01,
    GAIN_UP_6dB = 2'b10,
    GAIN_DW_6dB = 2'b11
  } gain_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  // Clamp x to [-2^(wd-1), 2^(wd-1)-1]. Operates on 64 bits so one function
  // serves any accumulator width up to 64; callers slice the low wd bits.
  function automatic logic signed [63:0] sat(input logic signed [63:0] x,
                                             input int wd);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (wd - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (wd - 1));
    if (x > hi)      sat = hi;
    else if (x < lo) sat = lo;
    else             sat = x;
  endfunction

endpackage

// File: rtl/band_gain_scheduler_mul_gain.sv
// mul_gain: combinational 2-bit-select gain unit.
//   sel  in  2       gain select (KEEP / REMOVE / +6dB / -6dB)
//   din  in  WD_IN   signed sample
//   dout out WD_OUT  signed gained sample
// +6dB is a plain left shift that wraps within WD_IN bits (not saturated).
// -6dB halves with ties rounded upward: (x+1)>>>1, computed one bit wider so
// the largest positive input cannot overflow.
module mul_gain
  import gain_pkg::*;
#(
  parameter int WD_IN  = 24,
  parameter int WD_OUT = 24
) (
  input  logic [1:0]               sel,
  input  logic signed [WD_IN-1:0]  din,
  output logic signed [WD_OUT-1:0] dout
);

  localparam logic signed [WD_IN:0] ONE = (WD_IN+1)'(1);

  logic signed [WD_IN:0]   din_ext;
  logic signed [WD_IN:0]   half_up;
  logic signed [WD_IN-1:0] res;

  always_comb begin
    din_ext = {din[WD_IN-1], din};
    half_up = (din_ext + ONE) >>> 1;
    case (gain_sel_t'(sel))
      KEEP:        res = din;
      REMOVE:      res = '0;
      GAIN_UP_6dB: res = {din[WD_IN-2:0], 1'b0};
      GAIN_DW_6dB: res = half_up[WD_IN-1:0];
      default:     res = din;
    endcase
    dout = WD_OUT'(res);
  end

endmodule

// File: rtl/band_gain_scheduler.sv
// band_gain_scheduler: time-multiplexes one mul_gain across NUM_BANDS bands,
// accumulates the gained bands and emits one saturated mix per sample strobe.
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   cfg_we       in   write strobe for a band gain select
//   cfg_band     in   band index for the write (out-of-range ignored)
//   cfg_sel      in   gain select for the write
//   sample_valid in   one-cycle strobe, band_data valid
//   band_data    in   packed band samples, band i at [i*WD +: WD]
//   busy         out  high while bands are being sequenced (RUN)
//   out_valid    out  one-cycle strobe, out_data valid
//   out_data     out  saturated signed mix, held between strobes
//   overrun      out  one-cycle pulse when a strobe arrives during RUN
module band_gain_scheduler
  import gain_pkg::*;
#(
  parameter int NUM_BANDS = 4,
  parameter int WD        = 24,
  parameter int WD_ACC    = WD + $clog2(NUM_BANDS) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_BANDS)-1:0] cfg_band,
  input  logic [1:0]                   cfg_sel,
  input  logic                         sample_valid,
  input  logic [NUM_BANDS*WD-1:0]      band_data,
  output logic                         busy,
  output logic                         out_valid,
  output logic [WD-1:0]                out_data,
  output logic                         overrun
);

  localparam int IDX_W = $clog2(NUM_BANDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANDS - 1);

  sched_state_t state_reg, state_next;

  gain_sel_t               sel_cfg_reg    [NUM_BANDS];
  gain_sel_t               sel_act_reg    [NUM_BANDS];
  logic signed [WD-1:0]    sample_buf_reg [NUM_BANDS];

  logic signed [WD_ACC-1:0] acc_reg;
  logic [IDX_W-1:0]         idx_reg;
  logic                     out_valid_reg;
  logic [WD-1:0]            out_data_reg;
  logic                     overrun_reg;

  logic                     capture;
  logic signed [WD-1:0]     gain_out;
  logic signed [63:0]       sat_full;

  // A strobe is accepted only when no frame is being sequenced.
  assign capture = sample_valid && (state_reg == IDLE || state_reg == DONE);

  // Per-band config, active-select shadow and sample buffer. The shadow is
  // loaded on capture so config writes during RUN only affect the next frame;
  // a write coincident with capture lands after the shadow copy is taken.
  for (genvar gi = 0; gi < NUM_BANDS; gi++) begin : g_band
    always_ff @(posedge clk) begin
      if (rst) begin
        sel_cfg_reg[gi]    <= KEEP;
        sel_act_reg[gi]    <= KEEP;
        sample_buf_reg[gi] <= '0;
      end else begin
        if (cfg_we && cfg_band == IDX_W'(gi)) begin
          sel_cfg_reg[gi] <= gain_sel_t'(cfg_sel);
        end
        if (capture) begin
          sel_act_reg[gi]    <= sel_cfg_reg[gi];
          sample_buf_reg[gi] <= band_data[gi*WD +: WD];
        end
      end
    end
  end

  // Shared gain unit, steered by the band index.
  mul_gain #(
    .WD_IN  (WD),
    .WD_OUT (WD)
  ) u_mul_gain (
    .sel  (sel_act_reg[idx_reg]),
    .din  (sample_buf_reg[idx_reg]),
    .dout (gain_out)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (sample_valid) state_next = RUN;
      RUN:     if (idx_reg == LAST_IDX) state_next = DONE;
      DONE:    state_next = sample_valid ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_reg == RUN);
  end

  always_comb begin
    sat_full = sat(64'(acc_reg), WD);
  end

  // Datapath: accumulate one band per RUN cycle; publish the mix from DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg       <= '0;
      idx_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      overrun_reg   <= 1'b0;
    end else begin
      out_valid_reg <= (state_reg == DONE);
      overrun_reg   <= sample_valid && (state_reg == RUN);
      if (state_reg == DONE) begin
        out_data_reg <= sat_full[WD-1:0];
      end
      if (capture) begin
        acc_reg <= '0;
        idx_reg <= '0;
      end else if (state_reg == RUN) begin
        acc_reg <= acc_reg + WD_ACC'(gain_out);
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_band_gain_scheduler.sv
// Self-checking bench for band_gain_scheduler (NUM_BANDS=4, WD=24).
// Expected mixes come from an arithmetic model of the gain rules and a mirror
// of the per-band config, updated as writes and resets are issued.
module tb_band_gain_scheduler;

  localparam int NB = 4;
  localparam int WD = 24;
  localparam int BW = NB * WD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_band = '0;
  logic [1:0]    cfg_sel = '0;
  logic          sample_valid = 1'b0;
  logic [BW-1:0] band_data = '0;
  logic          busy;
  logic          out_valid;
  logic [WD-1:0] out_data;
  logic          overrun;

  int errors = 0;
  int checks = 0;
  int cfg_m[NB];
  logic [WD-1:0] last_out = '0;

  band_gain_scheduler #(.NUM_BANDS(NB), .WD(WD)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_band     (cfg_band),
    .cfg_sel      (cfg_sel),
    .sample_valid (sample_valid),
    .band_data    (band_data),
    .busy         (busy),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // Gain of one band: keep, zero, doubling wrapped to WD bits, or halving
  // with ties rounded toward +infinity.
  function automatic longint gain_model(input longint x, input int sel);
    longint y;
    case (sel)
      0: y = x;
      1: y = 0;
      2: begin
        y = 2 * x;
        y = ((y + 64'sd8388608) & 64'sh0FFFFFF) - 64'sd8388608;
      end
      default: y = (x + 1) >>> 1;
    endcase
    return y;
  endfunction

  function automatic longint frame_model(input logic [BW-1:0] d);
    longint sum;
    logic signed [WD-1:0] s;
    sum = 0;
    for (int i = 0; i < NB; i++) begin
      s = d[i*WD +: WD];
      sum += gain_model(longint'(s), cfg_m[i]);
    end
    if (sum > 64'sd8388607)  sum = 64'sd8388607;
    if (sum < -64'sd8388608) sum = -64'sd8388608;
    return sum;
  endfunction

  function automatic logic [BW-1:0] pack4(input longint b3, input longint b2,
                                          input longint b1, input longint b0);
    return {b3[WD-1:0], b2[WD-1:0], b1[WD-1:0], b0[WD-1:0]};
  endfunction

  function automatic longint rand_sample();
    longint v;
    case ($urandom_range(0, 2))
      0: v = longint'($urandom_range(0, 2000)) - 1000;
      1: v = longint'($urandom_range(0, 16777215)) - 8388608;
      default: begin
        v = longint'($urandom_range(5242880, 8388607));
        if ($urandom_range(0, 1) == 1) v = -v;
      end
    endcase
    return v;
  endfunction

  task automatic cfg_write(input int band, input int sel);
    cfg_we   = 1'b1;
    cfg_band = 2'(band);
    cfg_sel  = 2'(sel);
    @(negedge clk);
    cfg_we = 1'b0;
    cfg_m[band] = sel;
    $display("cfg write band=%0d sel=%0d", band, sel);
  endtask

  // Launch one frame and watch 16 cycles. action: 0 none, 1 config write
  // during RUN, 2 second strobe during RUN, 3 reset during RUN,
  // 4 second strobe in the DONE cycle. launch_we issues a config write in
  // the same cycle as the capture strobe.
  task automatic run_frame(input string name, input logic [BW-1:0] data,
                           input int action, input logic [BW-1:0] data2,
                           input int wband, input int wsel, input bit launch_we);
    longint exp1, exp2;
    int npulse, nov, nbusy, exp_pulses, exp_busy, exp_ov;
    int pc[2];
    logic [WD-1:0] pv[2];
    logic [WD-1:0] expv;

    exp1 = frame_model(data);
    sample_valid = 1'b1;
    band_data    = data;
    if (launch_we) begin
      cfg_we = 1'b1; cfg_band = 2'(wband); cfg_sel = 2'(wsel);
    end
    @(negedge clk);
    sample_valid = 1'b0;
    cfg_we = 1'b0;
    if (launch_we) cfg_m[wband] = wsel;

    npulse = 0; nov = 0; nbusy = 0;
    pc[0] = -1; pc[1] = -1; pv[0] = '0; pv[1] = '0;
    exp2 = 0;
    for (int c = 0; c < 16; c++) begin
      if (out_valid) begin
        if (npulse < 2) begin pc[npulse] = c; pv[npulse] = out_data; end
        npulse++;
      end
      if (overrun) nov++;
      if (busy) nbusy++;
      if (action == 3 && c == 2) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL %s busy_after_reset: got %b want 0", name, busy);
        end
      end
      if (c == 1 && action == 1) begin
        cfg_we = 1'b1; cfg_band = 2'(wband); cfg_sel = 2'(wsel);
        cfg_m[wband] = wsel;
      end
      if (c == 1 && action == 2) begin
        sample_valid = 1'b1; band_data = data2;
      end
      if (c == 1 && action == 3) begin
        rst = 1'b1;
        for (int i = 0; i < NB; i++) cfg_m[i] = 0;
      end
      if (c == 4 && action == 4) begin
        exp2 = frame_model(data2);
        sample_valid = 1'b1; band_data = data2;
      end
      if (c == 2 || c == 5) begin
        cfg_we = 1'b0; sample_valid = 1'b0; rst = 1'b0;
      end
      @(negedge clk);
    end

    exp_pulses = (action == 3) ? 0 : ((action == 4) ? 2 : 1);
    exp_busy   = (action == 3) ? 2 : ((action == 4) ? 8 : 4);
    exp_ov     = (action == 2) ? 1 : 0;

    checks++;
    if (npulse != exp_pulses) begin
      errors++;
      $display("FAIL %s out_valid_count: got %0d want %0d", name, npulse, exp_pulses);
    end
    checks++;
    if (nbusy != exp_busy) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, nbusy, exp_busy);
    end
    checks++;
    if (nov != exp_ov) begin
      errors++;
      $display("FAIL %s overrun_pulses: got %0d want %0d", name, nov, exp_ov);
    end
    if (exp_pulses >= 1) begin
      expv = exp1[WD-1:0];
      checks++;
      if (pc[0] != 5) begin
        errors++;
        $display("FAIL %s latency: got %0d want 5", name, pc[0]);
      end
      checks++;
      if (pv[0] !== expv) begin
        errors++;
        $display("FAIL %s out_data: got %h want %h", name, pv[0], expv);
      end
      last_out = expv;
    end
    if (exp_pulses == 2) begin
      expv = exp2[WD-1:0];
      checks++;
      if (pc[1] != 10) begin
        errors++;
        $display("FAIL %s latency2: got %0d want 10", name, pc[1]);
      end
      checks++;
      if (pv[1] !== expv) begin
        errors++;
        $display("FAIL %s out_data2: got %h want %h", name, pv[1], expv);
      end
      last_out = expv;
    end
    if (action == 3) last_out = '0;
    checks++;
    if (out_data !== last_out) begin
      errors++;
      $display("FAIL %s out_data_hold: got %h want %h", name, out_data, last_out);
    end
    $display("frame %s: action=%0d pulses=%0d out=%h busy=%0d overrun=%0d",
             name, action, npulse, pv[0], nbusy, nov);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NB; i++) cfg_m[i] = 0;
    last_out = '0;
    checks++;
    if ({busy, out_valid, overrun} !== 3'b000 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b ov=%b or=%b data=%h want 0",
               busy, out_valid, overrun, out_data);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b ov=%b want 0", busy, out_valid);
    end
    $display("reset applied");
  endtask

  task automatic test_default_keep();
    run_frame("keep_sum", pack4(400, 300, 200, 100), 0, '0, 0, 0, 1'b0);
  endtask

  task automatic test_gain_selects();
    cfg_write(0, 2);
    cfg_write(1, 1);
    cfg_write(2, 3);
    cfg_write(3, 0);
    run_frame("mixed_gain", pack4(-7, 301, 200, 100), 0, '0, 0, 0, 1'b0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < NB; i++) cfg_write(i, 0);
    run_frame("sat_pos", pack4(6291456, 6291456, 6291456, 6291456), 0, '0, 0, 0, 1'b0);
    run_frame("sat_neg", pack4(-6291456, -6291456, -6291456, -6291456), 0, '0, 0, 0, 1'b0);
  endtask

  task automatic test_overrun();
    run_frame("overrun", pack4(1, 2, 3, 4), 2, pack4(1000, 1000, 1000, 1000), 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_frame("back_to_back", pack4(10, 20, 30, 40), 4, pack4(-5, 7, 900, -300), 0, 0, 1'b0);
  endtask

  task automatic test_cfg_during_run();
    run_frame("cfg_run_a", pack4(100, 100, 100, 100), 1, '0, 2, 1, 1'b0);
    run_frame("cfg_run_b", pack4(100, 100, 100, 100), 0, '0, 0, 0, 1'b0);
  endtask

  task automatic test_cfg_at_capture();
    run_frame("cfg_cap_a", pack4(100, 100, 100, 100), 0, '0, 0, 1, 1'b1);
    run_frame("cfg_cap_b", pack4(100, 100, 100, 100), 0, '0, 0, 0, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    cfg_write(1, 1);
    run_frame("reset_mid", pack4(100, 100, 100, 100), 3, '0, 0, 0, 1'b0);
    run_frame("after_reset", pack4(100, 100, 100, 100), 0, '0, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [BW-1:0] d1, d2;
    int act, nw;
    for (int n = 0; n < 24; n++) begin
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++) cfg_write($urandom_range(0, NB-1), $urandom_range(0, 3));
      d1 = pack4(rand_sample(), rand_sample(), rand_sample(), rand_sample());
      d2 = pack4(rand_sample(), rand_sample(), rand_sample(), rand_sample());
      act = $urandom_range(0, 4);
      run_frame($sformatf("rand%0d", n), d1, act, d2,
                $urandom_range(0, NB-1), $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0) && (act != 1));
    end
  endtask

  initial begin
    test_reset();
    test_default_keep();
    test_gain_selects();
    test_saturation();
    test_overrun();
    test_back_to_back();
    test_cfg_during_run();
    test_cfg_at_capture();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
